// File: rtl/muldiv_unit_pkg.sv
// Shared types for the iterative RV32M multiply/divide unit.
// Operation encoding follows RV32M funct3 so decode can pass it through directly.
package muldiv_unit_pkg;

  localparam int XLEN_DEFAULT = 32;

  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } MulDivOperation_;

  typedef enum logic [1:0] {
    MD_IDLE  = 2'd0,
    MD_RUN   = 2'd1,
    MD_FIXUP = 2'd2,
    MD_DONE  = 2'd3
  } MulDivState_;

  function automatic logic op_a_signed(input MulDivOperation_ op);
    return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
  endfunction

  function automatic logic op_b_signed(input MulDivOperation_ op);
    return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
  endfunction

endpackage

// File: rtl/muldiv_unit_step.sv
// One iteration of the multiply/divide datapath: a shift-add step on the product
// accumulator, or a restoring-subtract step on the {remainder, dividend} pair.
module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic              i_div,
  input  logic [XLEN-1:0]   i_b,
  input  logic [2*XLEN-1:0] i_acc,
  output logic [2*XLEN-1:0] o_acc
);

  logic [XLEN-1:0] w_hi;
  logic [XLEN-1:0] w_lo;
  logic [XLEN-1:0] w_addend;
  logic [XLEN:0]   w_sum;
  logic [XLEN:0]   w_rem_sh;
  logic            w_ge;
  logic [XLEN-1:0] w_diff;
  logic [XLEN-1:0] w_new_rem;

  assign w_hi = i_acc[2*XLEN-1:XLEN];
  assign w_lo = i_acc[XLEN-1:0];

  // Multiply: add the multiplicand when the current multiplier bit is set, shift right.
  assign w_addend = w_lo[0] ? i_b : '0;
  assign w_sum    = {1'b0, w_hi} + {1'b0, w_addend};

  // Divide: remainder < divisor, so the shifted remainder needs only one extra bit
  // and a successful subtraction always fits back into XLEN bits.
  assign w_rem_sh  = {w_hi, w_lo[XLEN-1]};
  assign w_ge      = (w_rem_sh >= {1'b0, i_b});
  assign w_diff    = w_rem_sh[XLEN-1:0] - i_b;
  assign w_new_rem = w_ge ? w_diff : w_rem_sh[XLEN-1:0];

  assign o_acc = i_div ? {w_new_rem, w_lo[XLEN-2:0], w_ge}
                       : {w_sum, w_lo[XLEN-1:1]};

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit with valid/ready request and result ports.
// Works on operand magnitudes and restores signs in a single FIXUP cycle.
//
// state | meaning
// IDLE  | waiting for a request; inReady high
// RUN   | BITS_PER_CYCLE shift-add / restoring-subtract steps per cycle
// FIXUP | sign correction and high/low result select
// DONE  | result held; outValid raised one edge after entry, leaves on outReady
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int XLEN           = XLEN_DEFAULT,
  parameter int BITS_PER_CYCLE = 1,
  parameter int TAG_WIDTH      = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 inValid,
  output logic                 inReady,
  input  logic [2:0]           inOperation,
  input  logic [XLEN-1:0]      inOperandA,
  input  logic [XLEN-1:0]      inOperandB,
  input  logic [TAG_WIDTH-1:0] inTag,
  output logic                 outValid,
  input  logic                 outReady,
  output logic [XLEN-1:0]      outResult,
  output logic [TAG_WIDTH-1:0] outTag,
  output logic                 busy
);

  localparam int ITERS = XLEN / BITS_PER_CYCLE;
  localparam int CNT_W = (ITERS > 1) ? $clog2(ITERS) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ITERS - 1);

  MulDivState_          r_state;
  MulDivOperation_      r_op;
  logic [TAG_WIDTH-1:0] r_tag;
  logic [CNT_W-1:0]     r_cnt;
  logic [2*XLEN-1:0]    r_acc;
  logic [XLEN-1:0]      r_b;
  logic                 r_neg_q;
  logic                 r_neg_r;
  logic [XLEN-1:0]      r_result;
  logic                 r_out_valid;

  MulDivOperation_ w_op;
  logic            w_a_neg;
  logic            w_b_neg;
  logic [XLEN-1:0] w_a_mag;
  logic [XLEN-1:0] w_b_mag;
  logic            w_div_zero;
  logic            w_div_ovf;
  logic [XLEN-1:0] w_special_res;
  logic [XLEN-1:0] w_min_neg;

  assign inReady   = (r_state == MD_IDLE) && rst_n;
  assign busy      = (r_state != MD_IDLE);
  assign outValid  = r_out_valid;
  assign outResult = r_result;
  assign outTag    = r_tag;

  assign w_op      = MulDivOperation_'(inOperation);
  assign w_a_neg   = op_a_signed(w_op) && inOperandA[XLEN-1];
  assign w_b_neg   = op_b_signed(w_op) && inOperandB[XLEN-1];
  assign w_a_mag   = w_a_neg ? (~inOperandA + 1'b1) : inOperandA;
  assign w_b_mag   = w_b_neg ? (~inOperandB + 1'b1) : inOperandB;
  assign w_min_neg = {1'b1, {(XLEN-1){1'b0}}};

  // Division corner cases resolve at acceptance and skip the iterative path.
  assign w_div_zero = inOperation[2] && (inOperandB == '0);
  assign w_div_ovf  = ((w_op == MD_DIV) || (w_op == MD_REM)) &&
                      (inOperandA == w_min_neg) && (inOperandB == {XLEN{1'b1}});

  always_comb begin
    w_special_res = '0;
    if (w_div_zero)
      w_special_res = inOperation[1] ? inOperandA : {XLEN{1'b1}};
    else if (!inOperation[1])
      w_special_res = inOperandA;
  end

  logic [2*XLEN-1:0] w_chain [0:BITS_PER_CYCLE];
  assign w_chain[0] = r_acc;

  for (genvar g = 0; g < BITS_PER_CYCLE; g++) begin : g_step
    muldiv_step #(.XLEN(XLEN)) u_step (
      .i_div (r_op[2]),
      .i_b   (r_b),
      .i_acc (w_chain[g]),
      .o_acc (w_chain[g+1])
    );
  end

  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quot;
  logic [XLEN-1:0]   w_rem;
  logic [XLEN-1:0]   w_fix;

  assign w_prod = r_neg_q ? (~r_acc + 1'b1) : r_acc;
  assign w_quot = r_neg_q ? (~r_acc[XLEN-1:0] + 1'b1) : r_acc[XLEN-1:0];
  assign w_rem  = r_neg_r ? (~r_acc[2*XLEN-1:XLEN] + 1'b1) : r_acc[2*XLEN-1:XLEN];

  always_comb begin
    w_fix = '0;
    case (r_op)
      MD_MUL:                      w_fix = w_prod[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: w_fix = w_prod[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:             w_fix = w_quot;
      default:                     w_fix = w_rem;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= MD_IDLE;
      r_op        <= MD_MUL;
      r_tag       <= '0;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_b         <= '0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_result    <= '0;
      r_out_valid <= 1'b0;
    end else if (flush) begin
      r_state     <= MD_IDLE;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        MD_IDLE: begin
          if (inValid) begin
            r_op    <= w_op;
            r_tag   <= inTag;
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
            // Multiplier bits (or dividend bits) live in the low half of the accumulator.
            r_acc   <= {{XLEN{1'b0}}, (inOperation[2] ? w_a_mag : w_b_mag)};
            r_b     <= inOperation[2] ? w_b_mag : w_a_mag;
            if (w_div_zero || w_div_ovf) begin
              r_result <= w_special_res;
              r_state  <= MD_DONE;
            end else begin
              r_cnt   <= CNT_LOAD;
              r_state <= MD_RUN;
            end
          end
        end
        MD_RUN: begin
          r_acc <= w_chain[BITS_PER_CYCLE];
          if (r_cnt == '0)
            r_state <= MD_FIXUP;
          else
            r_cnt <= r_cnt - 1'b1;
        end
        MD_FIXUP: begin
          r_result <= w_fix;
          r_state  <= MD_DONE;
        end
        default: begin
          if (r_out_valid && outReady) begin
            r_out_valid <= 1'b0;
            r_state     <= MD_IDLE;
          end else begin
            r_out_valid <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide unit sitting beside the single-cycle ALU in the execute stage. It accepts one operation at a time over a valid/ready handshake and computes the product or quotient over `XLEN/BITS_PER_CYCLE` iterations. It returns the result, with its destination tag, over a second valid/ready handshake. Execute stalls on `inReady`/`outValid`, and a pipeline flush kills any in-flight operation.

## Interface
Parameters:
- `XLEN`, 32: operand/result width.
- `BITS_PER_CYCLE`, 1: iterations retired per clock. Legal values are 1, 2 and 4, and the value must divide `XLEN`.
- `TAG_WIDTH`, 5: width of the pass-through tag (rd index).

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `flush`  in  1  kill in-flight or pending operation.
- `inValid`  in  1  request valid.
- `inReady`  out  1  unit can accept; high only in IDLE.
- `inOperation`  in  3  `MulDivOperation_`.
- `inOperandA`  in  XLEN  rs1 value (multiplicand/dividend).
- `inOperandB`  in  XLEN  rs2 value (multiplier/divisor).
- `inTag`  in  TAG_WIDTH  returned unchanged on `outTag`.
- `outValid`  out  1  result valid.
- `outReady`  in  1  consumer takes result.
- `outResult`  out  XLEN  result.
- `outTag`  out  TAG_WIDTH  tag of result.
- `busy`  out  1  state != IDLE.

## Operation
- States: IDLE, RUN, FIXUP, DONE.
- IDLE -> RUN on `inValid && inReady && !flush`. Operands, operation and tag are latched at this point. Operand magnitudes are captured per signedness:
  - MULH, DIV, REM: both operands signed.
  - MULHSU: A signed, B unsigned.
  - MULU, MULHU, DIVU, REMU: both unsigned.
  - MUL: treated as unsigned; low bits are identical either way.
- Special cases go IDLE -> DONE directly:
  - Divide by zero: quotient = all ones; remainder = A.
  - Signed overflow (A = most negative, B = -1) for DIV/REM: quotient = A; remainder = 0.
- RUN, multiply: shift-add on magnitudes into a 2·XLEN accumulator, consuming `BITS_PER_CYCLE` multiplier bits per cycle.
- RUN, divide: restoring division producing `BITS_PER_CYCLE` quotient bits per cycle.
- A down-counter of width clog2(XLEN/BITS_PER_CYCLE) is loaded with `XLEN/BITS_PER_CYCLE - 1` at acceptance. RUN -> FIXUP when the counter reaches 0.
- FIXUP: conditional two's-complement negation.
  - Product is negated if operand signs differ.
  - Quotient is negated if signs differ.
  - Remainder takes the dividend's sign.
  - MUL/DIV*/REM* select the low XLEN bits; MULH* select the high XLEN bits. FIXUP -> DONE.
- DONE: `outValid`=1 with `outResult`/`outTag` stable. DONE -> IDLE on `outReady`.
- `flush` overrides every state: next edge -> IDLE, `outValid` deasserts, no result is emitted. `flush` with `inValid` in IDLE: the request is not accepted.
- Arithmetic is modulo 2^XLEN; there are no exceptions and no flags.

## Timing
- Reset values: state IDLE, `outValid`=0, `outResult`=0, `outTag`=0, `busy`=0, counter 0. `inReady`=0 while `rst_n` is low and 1 after release.
- Reset mid-operation drops the operation immediately (asynchronous).
- Normal latency: `outValid` rises on the `(XLEN/BITS_PER_CYCLE)+2`-th edge after the accepting edge. That is N RUN cycles, 1 FIXUP cycle and 1 DONE entry. Default: 34.
- Special-case latency: `outValid` rises on the 1st edge after acceptance.
- `inReady` is combinational from state only; it never depends on `inValid`.
- Result handshake completes on an edge where `outValid && outReady`. `inReady` rises on the following cycle, giving a one-cycle bubble between operations.
- `outResult`/`outTag` must not change while `outValid` is high and `outReady` is low.

## Structure
- `MulDivOperation_` is a 3-bit enum added to the shared `Enumerations` package, with encoding equal to RV32M funct3:
  - MUL=0, MULH=1, MULHSU=2, MULHU=3, DIV=4, DIVU=5, REM=6, REMU=7.
- The state enum `MulDivState_` also lives in `Enumerations`.
- `XLEN` is taken from `Configuration` at instantiation.
- One sub-module, `muldiv_step`: a combinational single-bit shift-add/restoring-subtract step. It is instantiated `BITS_PER_CYCLE` times in a chain.

## Test plan
- Multiply, XLEN=32, BITS_PER_CYCLE=1:
  - MUL 7 × 0xFFFFFFFD -> `outResult`=0xFFFFFFEB, `outValid` on edge 34.
  - MULH 0x80000000 × 0x80000000 -> 0x40000000.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU -> 2.
- Special cases, each with `outValid` on edge 1:
  - DIVU 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0.
- Handshake: hold `outReady`=0 for 5 cycles in DONE -> result/tag (tag 0x13) stable and `inReady`=0; then `inReady`=1 the cycle after the handshake.
- Flush and reset:
  - `flush` on RUN cycle 10 -> IDLE next edge, no `outValid`.
  - `flush`+`inValid` in IDLE -> not accepted.
  - `rst_n` low mid-RUN -> all outputs at reset values immediately.
- BITS_PER_CYCLE=4: MUL 0x12345678 × 0x10 -> 0x23456780, `outValid` on edge 10.
